int_arb_ctrl: RTL and testbench
===============================

Name: int_arb_ctrl

Overview:
- Parametrised successor to the three-line machine interrupt controller.
- Accepts NUM_IRQ interrupt sources. Each source is level- or edge-type, chosen per bit.
- Keeps a pending register, arbitrates with fixed priority (optional round-robin), and sequences interrupt entry and mret return with the ctrl pipeline through a registered FSM.
- Supports direct and vectored mtvec. Sits between the CLINT/PLIC source wires, the CSR file and ctrl.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (2..32).
- ID_W, 3, claim-ID width; must be >= clog2(NUM_IRQ).
- IRQ_EDGE, 8'h00, per-source type: 1 = rising-edge, 0 = level.
- CAUSE_BASE, 16, mcause code of source 0; source i reports CAUSE_BASE+i.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- irq_src  in  NUM_IRQ  raw interrupt lines, already synchronous to clk
- csr_int_mie  in  1  mstatus.MIE global enable
- csr_int_irq_en  in  NUM_IRQ  per-source enable (mie bits)
- csr_int_mtvec  in  32  trap vector; [1:0]=01 means vectored
- csr_int_epc  in  32  mepc, used on return
- ctrl_int_valid  in  1  current instruction fully retired
- ctrl_int_mret  in  1  current instruction is mret
- ctrl_int_epc  in  32  pc of the current instruction
- jtag_irq  in  1  debug request/mode; blocks interrupt entry
- int_ctrl_pcen  out  1  redirect pc this cycle
- int_ctrl_pc  out  32  redirect target
- int_ctrl_flush_req  out  1  pipeline flush
- int_csr_ena  out  1  write mepc/mcause, update mstatus
- int_csr_epc  out  32  value for mepc
- int_csr_ecause  out  32  value for mcause
- int_csr_mret  out  1  restore mstatus
- int_csr_pend  out  NUM_IRQ  pending vector, for mip
- int_busy  out  1  handler active
- int_claim_id  out  ID_W  ID of the taken source

Behaviour:
- Reset (rstn low, async): all outputs 0, pending 0, edge-history 0, FSM in IDLE.
- Pending, level bit: pend[i] = irq_src[i].
- Pending, edge bit: set on irq_src rising edge (previous-cycle low, current high). Cleared in the TAKE cycle when claim_id == i. Set beats clear in the same cycle.
- Request: req = pend & csr_int_irq_en. Winner = lowest set index. any_req = mie & |req & ~jtag_irq.
- FSM IDLE:
  - If ctrl_int_valid & ctrl_int_mret, go to RET.
  - Else if any_req, latch winner into claim_id and go to ARM.
  - mret has priority over a simultaneous request.
- FSM ARM:
  - If any_req has dropped (source deasserted, mie cleared or jtag_irq asserted), return to IDLE with no side effects.
  - Else if ctrl_int_valid, sample ctrl_int_epc and go to TAKE.
  - While in ARM, claim_id is re-evaluated every cycle, so the winner is final at the valid edge.
- FSM TAKE (one cycle):
  - int_ctrl_pcen = int_csr_ena = flush = 1.
  - int_csr_epc = sampled epc + 4 (32-bit wrap).
  - int_csr_ecause = {1'b1, 31'(CAUSE_BASE+claim_id)}.
  - int_ctrl_pc = {mtvec[31:2], 2'b00}, plus 4*(CAUSE_BASE+claim_id) when vectored.
  - Next state HANDLER.
- FSM HANDLER:
  - int_busy = 1. New requests are ignored.
  - ctrl_int_valid & ctrl_int_mret goes to RET.
- FSM RET (one cycle):
  - int_ctrl_pcen = int_csr_mret = flush = 1; int_ctrl_pc = csr_int_epc.
  - Next state IDLE. A request pending at this point is re-armed from IDLE on the following cycle.
- Flush stretch: int_ctrl_flush_req is asserted in TAKE/RET and held one extra cycle after each.
- Latency: valid sampled in ARM at cycle t gives pcen at t+1. Raw edge to ARM is 1 cycle.
- Outputs: int_ctrl_pcen, int_ctrl_pc, int_csr_ena, int_csr_epc, int_csr_ecause, int_csr_mret and int_claim_id are registered (Moore). They are 0 outside their active states; int_claim_id holds its value.
- Reset mid-handler returns to IDLE. Edge events during reset are lost.

Optional Feature:
- Macro INT_ARB_RR_EN.
- Defined: round-robin arbitration. A last-granted pointer updates at TAKE, and the search starts at pointer+1 with wrap at NUM_IRQ. Pointer resets to NUM_IRQ-1, so source 0 is searched first.
- Undefined: fixed priority, lowest index wins; no pointer register.

Test Plan:
- Level src2 high, en=FF, mie=1, ctrl_int_valid pulse with epc=0x100, mtvec=0x8000_0000 -> pcen 1 cycle later, pc=0x8000_0000, epc=0x104, cause=0x8000_0012, claim_id=2, flush 2 cycles.
- Same with mtvec=0x8000_0001 (vectored) -> pc=0x8000_0048.
- IRQ_EDGE bit0: 1-cycle pulse on src0 while in HANDLER; then mret with csr_int_epc=0x104 -> RET pcen, pc=0x104, int_csr_mret=1; then re-entry with claim_id=0 and pend[0] cleared at TAKE.
- src1 and src5 asserted together -> claim 1. With INT_ARB_RR_EN, after 1 is serviced and both are still high -> claim 5.
- ARM with jtag_irq raised before valid -> back to IDLE, no pcen/csr_ena. Same result when the level source drops in ARM.
- rstn low asserted in HANDLER -> all outputs 0 immediately, int_busy=0, pend cleared.

Source files
------------

// File: rtl/int_arb_ctrl.sv
// Interrupt arbiter/sequencer: pending capture, arbitration and entry/mret FSM toward ctrl and the CSR file.
// Optional macro INT_ARB_RR_EN selects round-robin arbitration; the default is fixed lowest-index priority.
module int_arb_ctrl #(
  parameter int                 NUM_IRQ    = 8,
  parameter int                 ID_W       = 3,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE   = '0,
  parameter int                 CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               csr_int_mie,
  input  logic [NUM_IRQ-1:0] csr_int_irq_en,
  input  logic [31:0]        csr_int_mtvec,
  input  logic [31:0]        csr_int_epc,
  input  logic               ctrl_int_valid,
  input  logic               ctrl_int_mret,
  input  logic [31:0]        ctrl_int_epc,
  input  logic               jtag_irq,
  output logic               int_ctrl_pcen,
  output logic [31:0]        int_ctrl_pc,
  output logic               int_ctrl_flush_req,
  output logic               int_csr_ena,
  output logic [31:0]        int_csr_epc,
  output logic [31:0]        int_csr_ecause,
  output logic               int_csr_mret,
  output logic [NUM_IRQ-1:0] int_csr_pend,
  output logic               int_busy,
  output logic [ID_W-1:0]    int_claim_id
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_TAKE, S_HANDLER, S_RET} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    claim_reg, claim_next, winner;
  logic [NUM_IRQ-1:0] pend, req;
  logic               any_req;

  logic               pcen_next, ena_next, mret_next, flush_next, busy_next;
  logic [31:0]        pc_next, epc_next, ecause_next;
  logic [30:0]        cause_code;

  // Edge sources keep their own history/pending flops; level sources are plain wires.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      if (IRQ_EDGE[gi]) begin : g_edge
        logic hist_reg, pend_reg, rise, clr;
        assign rise = irq_src[gi] & ~hist_reg;
        assign clr  = (state_reg == S_TAKE) && (claim_reg == ID_W'(gi));
        assign pend[gi] = pend_reg | rise;
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            hist_reg <= 1'b0;
            pend_reg <= 1'b0;
          end else begin
            hist_reg <= irq_src[gi];
            pend_reg <= rise | (pend_reg & ~clr);
          end
        end
      end else begin : g_level
        assign pend[gi] = irq_src[gi];
      end
    end
  endgenerate

  assign req          = pend & csr_int_irq_en;
  assign any_req      = csr_int_mie & (|req) & ~jtag_irq;
  assign int_csr_pend = pend;
  assign int_claim_id = claim_reg;

`ifdef INT_ARB_RR_EN
  logic [ID_W-1:0] ptr_reg, win_hi, win_lo;
  logic            found_hi;

  // Prefer the lowest request above the last grant, else wrap to the lowest overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) win_lo = ID_W'(i);
      if (req[i] && (ID_W'(i) > ptr_reg)) begin
        win_hi   = ID_W'(i);
        found_hi = 1'b1;
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    ptr_reg <= ID_W'(NUM_IRQ - 1);
    else if (state_reg == S_TAKE) ptr_reg <= claim_reg;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      claim_reg <= '0;
    end else begin
      state_reg <= state_next;
      claim_reg <= claim_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    claim_next = claim_reg;
    case (state_reg)
      S_IDLE: begin
        if (ctrl_int_valid && ctrl_int_mret) begin
          state_next = S_RET;
        end else if (any_req) begin
          claim_next = winner;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (!any_req) begin
          state_next = S_IDLE;
        end else begin
          claim_next = winner;
          if (ctrl_int_valid) state_next = S_TAKE;
        end
      end
      S_TAKE:    state_next = S_HANDLER;
      S_HANDLER: if (ctrl_int_valid && ctrl_int_mret) state_next = S_RET;
      S_RET:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so they line up with the state they belong to.
  always_comb begin
    cause_code  = 31'(CAUSE_BASE) + 31'(claim_next);
    pcen_next   = 1'b0;
    ena_next    = 1'b0;
    mret_next   = 1'b0;
    busy_next   = 1'b0;
    pc_next     = '0;
    epc_next    = '0;
    ecause_next = '0;
    flush_next  = (state_next == S_TAKE) || (state_next == S_RET) ||
                  (state_reg == S_TAKE) || (state_reg == S_RET);
    case (state_next)
      S_TAKE: begin
        pcen_next   = 1'b1;
        ena_next    = 1'b1;
        epc_next    = ctrl_int_epc + 32'd4;
        ecause_next = {1'b1, cause_code};
        pc_next     = {csr_int_mtvec[31:2], 2'b00} +
                      ((csr_int_mtvec[1:0] == 2'b01) ? {cause_code[29:0], 2'b00} : 32'd0);
      end
      S_RET: begin
        pcen_next = 1'b1;
        mret_next = 1'b1;
        pc_next   = csr_int_epc;
      end
      S_HANDLER: busy_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_ctrl_pcen      <= 1'b0;
      int_ctrl_pc        <= '0;
      int_ctrl_flush_req <= 1'b0;
      int_csr_ena        <= 1'b0;
      int_csr_epc        <= '0;
      int_csr_ecause     <= '0;
      int_csr_mret       <= 1'b0;
      int_busy           <= 1'b0;
    end else begin
      int_ctrl_pcen      <= pcen_next;
      int_ctrl_pc        <= pc_next;
      int_ctrl_flush_req <= flush_next;
      int_csr_ena        <= ena_next;
      int_csr_epc        <= epc_next;
      int_csr_ecause     <= ecause_next;
      int_csr_mret       <= mret_next;
      int_busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_int_arb_ctrl.sv
// Self-checking bench for int_arb_ctrl: vector table of interrupt entries plus hand-written corner sequences.
// Redirects are checked by a scoreboard queue filled when stimulus is driven.
module tb_int_arb_ctrl;

  logic        clk;
  logic        rstn;
  logic [7:0]  irq_src;
  logic        csr_int_mie;
  logic [7:0]  csr_int_irq_en;
  logic [31:0] csr_int_mtvec;
  logic [31:0] csr_int_epc;
  logic        ctrl_int_valid;
  logic        ctrl_int_mret;
  logic [31:0] ctrl_int_epc;
  logic        jtag_irq;
  logic        int_ctrl_pcen;
  logic [31:0] int_ctrl_pc;
  logic        int_ctrl_flush_req;
  logic        int_csr_ena;
  logic [31:0] int_csr_epc;
  logic [31:0] int_csr_ecause;
  logic        int_csr_mret;
  logic [7:0]  int_csr_pend;
  logic        int_busy;
  logic [2:0]  int_claim_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  en;
    logic [31:0] mtvec;
    logic [31:0] epc;
    logic [2:0]  claim;
    logic [31:0] pc;
    logic [31:0] epc_exp;
    logic [31:0] cause;
  } vec_t;

  typedef struct {
    bit          is_ret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [2:0]  claim;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[6];

  int_arb_ctrl #(
    .NUM_IRQ(8), .ID_W(3), .IRQ_EDGE(8'h01), .CAUSE_BASE(16)
  ) dut (
    .clk(clk), .rstn(rstn), .irq_src(irq_src), .csr_int_mie(csr_int_mie),
    .csr_int_irq_en(csr_int_irq_en), .csr_int_mtvec(csr_int_mtvec), .csr_int_epc(csr_int_epc),
    .ctrl_int_valid(ctrl_int_valid), .ctrl_int_mret(ctrl_int_mret), .ctrl_int_epc(ctrl_int_epc),
    .jtag_irq(jtag_irq), .int_ctrl_pcen(int_ctrl_pcen), .int_ctrl_pc(int_ctrl_pc),
    .int_ctrl_flush_req(int_ctrl_flush_req), .int_csr_ena(int_csr_ena), .int_csr_epc(int_csr_epc),
    .int_csr_ecause(int_csr_ecause), .int_csr_mret(int_csr_mret), .int_csr_pend(int_csr_pend),
    .int_busy(int_busy), .int_claim_id(int_claim_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp_v);
    chk(nm, {31'b0, act}, {31'b0, exp_v});
  endfunction

  // Scoreboard: every redirect pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && int_ctrl_pcen) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pcen actual=pc %h expected=no redirect t=%0t", int_ctrl_pc, $time);
      end else begin
        e = sb_q.pop_front();
        chk("redirect_pc", int_ctrl_pc, e.pc);
        chk1("redirect_flush", int_ctrl_flush_req, 1'b1);
        if (e.is_ret) begin
          chk1("ret_mret", int_csr_mret, 1'b1);
          chk1("ret_no_ena", int_csr_ena, 1'b0);
          $display("ret   pc=%h", int_ctrl_pc);
        end else begin
          chk1("take_ena", int_csr_ena, 1'b1);
          chk1("take_no_mret", int_csr_mret, 1'b0);
          chk("take_epc", int_csr_epc, e.epc);
          chk("take_cause", int_csr_ecause, e.cause);
          chk("take_claim", {29'b0, int_claim_id}, {29'b0, e.claim});
          $display("take  pc=%h epc=%h cause=%h claim=%0d", int_ctrl_pc, int_csr_epc, int_csr_ecause, int_claim_id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input vec_t v);
    exp_t e;
    irq_src        = v.src;
    csr_int_irq_en = v.en;
    csr_int_mtvec  = v.mtvec;
    tick();
    @(negedge clk);
    chk("arm_claim", {29'b0, int_claim_id}, {29'b0, v.claim});
    chk1("arm_no_pcen", int_ctrl_pcen, 1'b0);
    ctrl_int_valid = 1'b1;
    ctrl_int_epc   = v.epc;
    e.is_ret = 1'b0; e.pc = v.pc; e.epc = v.epc_exp; e.cause = v.cause; e.claim = v.claim;
    sb_q.push_back(e);
    tick();
    ctrl_int_valid = 1'b0;
    @(negedge clk);
    chk1("take_latency", int_ctrl_pcen, 1'b1);
    tick();
    @(negedge clk);
    chk1("flush_stretch", int_ctrl_flush_req, 1'b1);
    chk1("handler_busy", int_busy, 1'b1);
    chk1("pcen_single", int_ctrl_pcen, 1'b0);
    tick();
    @(negedge clk);
    chk1("flush_end", int_ctrl_flush_req, 1'b0);
  endtask

  task automatic do_ret();
    exp_t e;
    ctrl_int_valid = 1'b1;
    ctrl_int_mret  = 1'b1;
    e.is_ret = 1'b1; e.pc = csr_int_epc; e.epc = '0; e.cause = '0; e.claim = '0;
    sb_q.push_back(e);
    tick();
    ctrl_int_valid = 1'b0;
    ctrl_int_mret  = 1'b0;
    @(negedge clk);
    chk1("ret_pcen", int_ctrl_pcen, 1'b1);
    tick();
  endtask

  initial begin
    exp_t e;
    vec_t v_pair1, v_pair2, v_src2, v_edge0;

    //          src    en     mtvec         epc           claim pc            epc_exp       cause
    tbl[0] = '{8'h04, 8'hFF, 32'h8000_0000, 32'h0000_0100, 3'd2, 32'h8000_0000, 32'h0000_0104, 32'h8000_0012};
    tbl[1] = '{8'h04, 8'hFF, 32'h8000_0001, 32'h0000_0100, 3'd2, 32'h8000_0048, 32'h0000_0104, 32'h8000_0012};
    tbl[2] = '{8'h80, 8'hFF, 32'h0000_1001, 32'hFFFF_FFFC, 3'd7, 32'h0000_105C, 32'h0000_0000, 32'h8000_0017};
    tbl[3] = '{8'h10, 8'hFF, 32'h0000_2002, 32'h0000_0300, 3'd4, 32'h0000_2000, 32'h0000_0304, 32'h8000_0014};
    tbl[4] = '{8'h0C, 8'h08, 32'h8000_0000, 32'h0000_0400, 3'd3, 32'h8000_0000, 32'h0000_0404, 32'h8000_0013};
    tbl[5] = '{8'h08, 8'hFF, 32'h4000_0001, 32'h0000_07FC, 3'd3, 32'h4000_004C, 32'h0000_0800, 32'h8000_0013};
    v_pair1 = '{8'h22, 8'hFF, 32'h8000_0000, 32'h0000_0010, 3'd1, 32'h8000_0000, 32'h0000_0014, 32'h8000_0011};
`ifdef INT_ARB_RR_EN
    v_pair2 = '{8'h22, 8'hFF, 32'h8000_0000, 32'h0000_0020, 3'd5, 32'h8000_0000, 32'h0000_0024, 32'h8000_0015};
`else
    v_pair2 = '{8'h22, 8'hFF, 32'h8000_0000, 32'h0000_0020, 3'd1, 32'h8000_0000, 32'h0000_0024, 32'h8000_0011};
`endif
    v_src2  = tbl[0];
    v_edge0 = '{8'h00, 8'hFF, 32'h8000_0000, 32'h0000_0500, 3'd0, 32'h8000_0000, 32'h0000_0504, 32'h8000_0010};

    rstn = 1'b0; irq_src = '0; csr_int_mie = 1'b1; csr_int_irq_en = 8'hFF;
    csr_int_mtvec = 32'h8000_0000; csr_int_epc = 32'h0000_0104;
    ctrl_int_valid = 1'b0; ctrl_int_mret = 1'b0; ctrl_int_epc = '0; jtag_irq = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk1("rst_pcen", int_ctrl_pcen, 1'b0);
    chk1("rst_busy", int_busy, 1'b0);
    chk1("rst_flush", int_ctrl_flush_req, 1'b0);
    chk("rst_claim", {29'b0, int_claim_id}, 32'd0);
    chk("rst_pend", {24'b0, int_csr_pend}, 32'd0);
    rstn = 1'b1;
    tick();

    // Simultaneous sources 1 and 5, serviced twice with both still asserted.
    do_entry(v_pair1);
    do_ret();
    do_entry(v_pair2);
    irq_src = '0;
    do_ret();

    for (int i = 0; i < 6; i++) begin
      do_entry(tbl[i]);
      irq_src = '0;
      do_ret();
    end

    // mret in IDLE wins over a request arriving in the same cycle.
    irq_src = 8'h04; csr_int_irq_en = 8'hFF; csr_int_mtvec = 32'h8000_0000;
    ctrl_int_valid = 1'b1; ctrl_int_mret = 1'b1;
    e.is_ret = 1'b1; e.pc = csr_int_epc; e.epc = '0; e.cause = '0; e.claim = '0;
    sb_q.push_back(e);
    tick();
    ctrl_int_valid = 1'b0; ctrl_int_mret = 1'b0;
    @(negedge clk);
    chk1("mret_prio_ret", int_csr_mret, 1'b1);
    tick();
    do_entry(v_src2);

    // One-cycle edge pulse on source 0 while the handler runs.
    irq_src = 8'h01;
    #1;
    chk1("edge_pend_rise", int_csr_pend[0], 1'b1);
    tick();
    irq_src = '0;
    @(negedge clk);
    chk1("edge_pend_held", int_csr_pend[0], 1'b1);
    chk1("handler_ignores_req", int_ctrl_pcen, 1'b0);
    chk("handler_claim_hold", {29'b0, int_claim_id}, 32'd2);
    do_ret();
    do_entry(v_edge0);
    chk1("edge_pend_cleared", int_csr_pend[0], 1'b0);
    do_ret();

    // Abort from ARM: debug request, then a dropped level source, each with valid high.
    irq_src = 8'h40;
    tick();
    @(negedge clk);
    chk("abort_arm_claim", {29'b0, int_claim_id}, 32'd6);
    jtag_irq = 1'b1; ctrl_int_valid = 1'b1; ctrl_int_epc = 32'h0000_0600;
    tick();
    ctrl_int_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("jtag_no_pcen", int_ctrl_pcen, 1'b0);
      chk1("jtag_no_ena", int_csr_ena, 1'b0);
      chk1("jtag_no_busy", int_busy, 1'b0);
      tick();
    end
    jtag_irq = 1'b0;
    tick();
    @(negedge clk);
    chk("rearm_claim", {29'b0, int_claim_id}, 32'd6);
    irq_src = '0; ctrl_int_valid = 1'b1;
    tick();
    ctrl_int_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("drop_no_pcen", int_ctrl_pcen, 1'b0);
      chk1("drop_no_ena", int_csr_ena, 1'b0);
      tick();
    end

    // Asynchronous reset while in HANDLER with an edge pending.
    do_entry(v_src2);
    irq_src = 8'h01;
    tick();
    irq_src = '0;
    @(negedge clk);
    chk1("pre_rst_busy", int_busy, 1'b1);
    chk1("pre_rst_pend", int_csr_pend[0], 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk1("midrst_busy", int_busy, 1'b0);
    chk1("midrst_pcen", int_ctrl_pcen, 1'b0);
    chk("midrst_pend", {24'b0, int_csr_pend}, 32'd0);
    chk("midrst_claim", {29'b0, int_claim_id}, 32'd0);
    chk("midrst_pc", int_ctrl_pc, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk1("post_rst_idle", int_busy, 1'b0);
    chk1("post_rst_no_pcen", int_ctrl_pcen, 1'b0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
